// File: rtl/pueo_trig_readout_sched.sv
// Trigger-time FIFO plus channel-major readout address sequencer for the signal buffer.
// Optional statistics counters are enabled by defining PUEO_TRIG_SCHED_STATS_EN.
module pueo_trig_readout_sched #(
   parameter int unsigned NCHAN           = 8,
   parameter int unsigned TRIGBIT         = 15,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned PRETRIG         = 512,
   parameter int unsigned READLEN         = 1024,
   localparam int unsigned CBITS          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                       memclk_i,
   input  logic                       memclk_aresetn_i,
   input  logic                       sigbuf_start_i,
   input  logic                       sigbuf_stop_i,
   input  logic [TRIGBIT-1:0]         trig_time_i,
   input  logic                       trig_valid_i,
   output logic [TRIGBIT-1:0]         rd_addr_o,
   output logic [CBITS-1:0]           rd_chan_o,
   output logic                       rd_valid_o,
   input  logic                       rd_ready_i,
   output logic                       event_done_o,
   output logic                       running_o,
   output logic [FIFO_DEPTH_LOG2:0]   pending_o,
   output logic                       overflow_o
`ifdef PUEO_TRIG_SCHED_STATS_EN
   ,
   output logic [31:0]                trig_count_o,
   output logic [15:0]                drop_count_o
`endif
);

   localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int unsigned PW    = FIFO_DEPTH_LOG2;
   localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;

   localparam logic [TRIGBIT-1:0] PRE       = TRIGBIT'(PRETRIG);
   localparam logic [TRIGBIT-1:0] BEAT_LAST = TRIGBIT'(READLEN - 1);
   localparam logic [CBITS-1:0]   CHAN_LAST = CBITS'(NCHAN - 1);
   localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

   state_t             state, state_nxt;
   logic [TRIGBIT-1:0] fifo_mem [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic               empty, full, push, pop, drop, accept;
   logic [TRIGBIT-1:0] head;
   logic [TRIGBIT-1:0] base, base_nxt, addr_nxt, beat, beat_nxt;
   logic [CBITS-1:0]   chan_nxt;
   logic               valid_nxt, done_nxt;

   assign empty  = (pending_o == '0);
   assign full   = (pending_o == FULL_CNT);
   assign pop    = (state == LOAD) && !sigbuf_stop_i;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept
   assign push   = trig_valid_i && running_o && !sigbuf_stop_i && (!full || pop);
   assign drop   = trig_valid_i && running_o && !sigbuf_stop_i && full && !pop;
   assign accept = (state == READ) && rd_ready_i;
   assign head   = fifo_mem[rd_ptr];

   // State register
   always_ff @(posedge memclk_i or negedge memclk_aresetn_i) begin
      if (!memclk_aresetn_i) state <= IDLE;
      else                   state <= state_nxt;
   end

   // Next-state logic; stop aborts any event in flight
   always_comb begin
      state_nxt = state;
      if (sigbuf_stop_i) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (!empty && running_o) state_nxt = LOAD;
            LOAD: state_nxt = READ;
            READ: if (accept && (beat == BEAT_LAST) && (rd_chan_o == CHAN_LAST))
                     state_nxt = DONE;
            DONE: state_nxt = empty ? IDLE : LOAD;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output / datapath next values; each channel restarts at the event base
   always_comb begin
      base_nxt  = base;
      addr_nxt  = rd_addr_o;
      beat_nxt  = beat;
      chan_nxt  = rd_chan_o;
      valid_nxt = (state_nxt == READ);
      done_nxt  = (state_nxt == DONE);
      if (state == LOAD) begin
         base_nxt = head;
         addr_nxt = head;
         beat_nxt = '0;
         chan_nxt = '0;
      end else if (accept) begin
         if (beat == BEAT_LAST) begin
            beat_nxt = '0;
            addr_nxt = base;
            chan_nxt = rd_chan_o + CBITS'(1);
         end else begin
            beat_nxt = beat + TRIGBIT'(1);
            addr_nxt = rd_addr_o + TRIGBIT'(1);
         end
      end
   end

   always_ff @(posedge memclk_i or negedge memclk_aresetn_i) begin
      if (!memclk_aresetn_i) begin
         base         <= '0;
         beat         <= '0;
         rd_addr_o    <= '0;
         rd_chan_o    <= '0;
         rd_valid_o   <= 1'b0;
         event_done_o <= 1'b0;
      end else begin
         base         <= base_nxt;
         beat         <= beat_nxt;
         rd_addr_o    <= addr_nxt;
         rd_chan_o    <= chan_nxt;
         rd_valid_o   <= valid_nxt;
         event_done_o <= done_nxt;
      end
   end

   // FIFO storage holds the pre-trigger start address, not the raw time
   always_ff @(posedge memclk_i) begin
      if (push) fifo_mem[wr_ptr] <= trig_time_i - PRE;
   end

   always_ff @(posedge memclk_i or negedge memclk_aresetn_i) begin
      if (!memclk_aresetn_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pending_o <= '0;
      end else if (sigbuf_stop_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pending_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         pending_o <= pending_o + CW'(push) - CW'(pop);
      end
   end

   // Run flag and sticky overflow; stop has priority over start
   always_ff @(posedge memclk_i or negedge memclk_aresetn_i) begin
      if (!memclk_aresetn_i) begin
         running_o  <= 1'b0;
         overflow_o <= 1'b0;
      end else if (sigbuf_stop_i) begin
         running_o  <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         if (sigbuf_start_i) running_o <= 1'b1;
         if (drop)           overflow_o <= 1'b1;
      end
   end

`ifdef PUEO_TRIG_SCHED_STATS_EN
   // Saturating statistics, cleared only by reset
   always_ff @(posedge memclk_i or negedge memclk_aresetn_i) begin
      if (!memclk_aresetn_i) begin
         trig_count_o <= '0;
         drop_count_o <= '0;
      end else begin
         if (push && (trig_count_o != '1)) trig_count_o <= trig_count_o + 32'd1;
         if (drop && (drop_count_o != '1)) drop_count_o <= drop_count_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pueo_trig_readout_sched.sv
// Directed self-checking bench for pueo_trig_readout_sched with default parameters.
module tb_pueo_trig_readout_sched;

   localparam int RLEN  = 1024;
   localparam int NCH   = 8;
   localparam int AMOD  = 32768;
   localparam int PRE   = 512;
   localparam int TOTAL = RLEN * NCH;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [14:0] trig_time;
   logic        trig_valid;
   logic [14:0] rd_addr;
   logic [2:0]  rd_chan;
   logic        rd_valid;
   logic        rd_ready;
   logic        event_done;
   logic        running;
   logic [4:0]  pending;
   logic        overflow;
`ifdef PUEO_TRIG_SCHED_STATS_EN
   logic [31:0] trig_count;
   logic [15:0] drop_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pueo_trig_readout_sched dut (
      .memclk_i         (clk),
      .memclk_aresetn_i (rst_n),
      .sigbuf_start_i   (start),
      .sigbuf_stop_i    (stop),
      .trig_time_i      (trig_time),
      .trig_valid_i     (trig_valid),
      .rd_addr_o        (rd_addr),
      .rd_chan_o        (rd_chan),
      .rd_valid_o       (rd_valid),
      .rd_ready_i       (rd_ready),
      .event_done_o     (event_done),
      .running_o        (running),
      .pending_o        (pending),
      .overflow_o       (overflow)
`ifdef PUEO_TRIG_SCHED_STATS_EN
      ,
      .trig_count_o     (trig_count),
      .drop_count_o     (drop_count)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int start_of(input int t);
      return (t - PRE + AMOD) % AMOD;
   endfunction

   // Push one trigger into an empty scheduler and check the 2-cycle latency to first beat
   task automatic push_and_wait(input int t, input string tag);
      trig_valid = 1'b1;
      trig_time  = 15'(t);
      step();
      trig_valid = 1'b0;
      chk({tag, "_pend_push"}, 32'(pending), 1);
      chk({tag, "_valid_n0"}, 32'(rd_valid), 0);
      step();
      chk({tag, "_valid_n1"}, 32'(rd_valid), 0);
      step();
      chk({tag, "_valid_n2"}, 32'(rd_valid), 1);
      chk({tag, "_addr0"}, 32'(rd_addr), start_of(t));
      chk({tag, "_chan0"}, 32'(rd_chan), 0);
   endtask

   // Drain one whole event; ends at the DONE cycle
   task automatic run_event(input int t, input int pct, input string tag);
      int n;
      int cyc;
      int s;
      n   = 0;
      cyc = 0;
      s   = start_of(t);
      while (n < TOTAL && cyc < 40000) begin
         rd_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
         chk({tag, "_valid"}, 32'(rd_valid), 1);
         chk({tag, "_addr"}, 32'(rd_addr), (s + (n % RLEN)) % AMOD);
         chk({tag, "_chan"}, 32'(rd_chan), n / RLEN);
         step();
         cyc++;
         if (rd_ready) n++;
      end
      chk({tag, "_beats"}, n, TOTAL);
      chk({tag, "_done"}, 32'(event_done), 1);
      chk({tag, "_valid_end"}, 32'(rd_valid), 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      trig_time  = '0;
      trig_valid = 1'b0;
      rd_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_running", 32'(running), 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_done", 32'(event_done), 0);
      chk("rst_addr", 32'(rd_addr), 0);
      rst_n = 1'b1;
      step();

      // Basic event
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_running", 32'(running), 1);
      push_and_wait(4000, "basic");
      run_event(4000, 100, "basic");
      step();
      chk("basic_done_pulse", 32'(event_done), 0);
      chk("basic_idle_valid", 32'(rd_valid), 0);

      // Address wrap across 2^15
      push_and_wait(100, "wrap");
      run_event(100, 100, "wrap");
      step();
      chk("wrap_done_pulse", 32'(event_done), 0);

      // Random backpressure
      push_and_wait(20000, "bp");
      run_event(20000, 30, "bp");
      step();
      chk("bp_done_pulse", 32'(event_done), 0);

      // Overflow while readout is stalled
      rd_ready = 1'b0;
      push_and_wait(6000, "ovf");
      for (int i = 0; i < 17; i++) begin
         trig_valid = 1'b1;
         trig_time  = 15'(1000 + i);
         step();
         chk("ovf_pending", 32'(pending), (i + 1 > 16) ? 16 : i + 1);
         chk("ovf_flag", 32'(overflow), (i == 16) ? 1 : 0);
         chk("ovf_stall_addr", 32'(rd_addr), start_of(6000));
      end
      trig_valid = 1'b0;
      step();
      chk("ovf_sticky", 32'(overflow), 1);
      chk("ovf_pending_hold", 32'(pending), 16);
      run_event(6000, 100, "ovf_ev");
      chk("ovf_done_pending", 32'(pending), 16);
      step();
      chk("load_valid", 32'(rd_valid), 0);
      chk("load_pending", 32'(pending), 16);
      // Push on a full FIFO in the same cycle as the pop
      trig_valid = 1'b1;
      trig_time  = 15'(2000);
      step();
      trig_valid = 1'b0;
      chk("pushpop_pending", 32'(pending), 16);
      chk("pushpop_valid", 32'(rd_valid), 1);
      chk("pushpop_addr", 32'(rd_addr), start_of(1000));

      // Stop mid-event after beat 300 of channel 2
      rd_ready = 1'b1;
      for (int n = 0; n <= 2 * RLEN + 300; n++) begin
         chk("mid_addr", 32'(rd_addr), (start_of(1000) + (n % RLEN)) % AMOD);
         chk("mid_chan", 32'(rd_chan), n / RLEN);
         step();
      end
      chk("pre_stop_addr", 32'(rd_addr), start_of(1000) + 301);
      chk("pre_stop_chan", 32'(rd_chan), 2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_valid", 32'(rd_valid), 0);
      chk("stop_pending", 32'(pending), 0);
      chk("stop_overflow", 32'(overflow), 0);
      chk("stop_running", 32'(running), 0);
      for (int i = 0; i < 3; i++) begin
         chk("stop_no_done", 32'(event_done), 0);
         step();
      end
      trig_valid = 1'b1;
      trig_time  = 15'(3000);
      step();
      trig_valid = 1'b0;
      chk("stopped_ignore_pend", 32'(pending), 0);
      chk("stopped_ignore_ovf", 32'(overflow), 0);
      step();
      chk("stopped_valid", 32'(rd_valid), 0);

      // Restart resumes with an empty FIFO
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_running", 32'(running), 1);
      chk("restart_pending", 32'(pending), 0);
      chk("restart_overflow", 32'(overflow), 0);
      rd_ready = 1'b0;
      push_and_wait(512, "restart");
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("restart_stop_valid", 32'(rd_valid), 0);

      // Start and stop together while idle: stop wins
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("both_running", 32'(running), 0);
      trig_valid = 1'b1;
      trig_time  = 15'(7000);
      step();
      trig_valid = 1'b0;
      chk("both_pending", 32'(pending), 0);
      step();
      step();
      chk("both_valid", 32'(rd_valid), 0);
      chk("both_overflow", 32'(overflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
